mem_access: RTL and testbench

EX→WB memory-access stage of the MIPS32 pipeline, directly downstream of the ALU. It takes the ALU result as either a pass-through writeback value or an effective address. For loads and stores it runs a request/acknowledge transaction on the data bus, aligns and extends load data, and builds byte enables for stores. While a transaction is outstanding it stalls the upstream pipeline, and it registers all results into the MEM/WB boundary.

---
 rtl/mem_access.sv | 154 +++++++++++++++
 tb/tb_mem_access.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS32 EX->WB memory-access stage
// Runs the load/store bus handshake, aligns load data and registers the MEM/WB outputs.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_mem_op,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_wb_reg,
  input  logic        in_wb_en,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        addr_err,
  output logic [31:0] bad_vaddr
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [4:0]  reg_q;
  logic        wen_q;

  logic [1:0]  off;
  logic        is_mem, is_store, is_byte, is_half, aligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign off      = in_alu_out[1:0];
  assign is_mem   = in_mem_op inside {[OP_LB:OP_SW]};
  assign is_store = in_mem_op inside {[OP_SB:OP_SW]};
  assign is_byte  = in_mem_op inside {OP_LB, OP_LBU, OP_SB};
  assign is_half  = in_mem_op inside {OP_LH, OP_LHU, OP_SH};
  assign aligned  = is_byte || (is_half && !off[0]) || (off == 2'b00);

  assign stall = (state == IDLE && in_valid && is_mem && aligned) ||
                 (state == BUSY && !bus_ack);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = in_store_data;
    case (in_mem_op)
      OP_SB: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{in_store_data[7:0]}};
      end
      OP_SH: begin
        be_c    = off[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Little-endian lane pick: byte lane by full offset, halfword lane by offset[1].
  function automatic logic [31:0] load_align(input logic [3:0] op, input logic [1:0] a,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   load_align = {{24{b[7]}}, b};
      OP_LBU:  load_align = {24'd0, b};
      OP_LH:   load_align = {{16{h[15]}}, h};
      OP_LHU:  load_align = {16'd0, h};
      default: load_align = rdata;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_reg    <= 5'd0;
      wb_data   <= 32'd0;
      addr_err  <= 1'b0;
      bad_vaddr <= 32'd0;
      op_q      <= 4'd0;
      off_q     <= 2'd0;
      reg_q     <= 5'd0;
      wen_q     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_en    <= in_wb_en;
              wb_reg   <= in_wb_reg;
              wb_data  <= in_alu_out;
            end else if (!aligned) begin
              wb_valid  <= 1'b1;
              wb_en     <= 1'b0;
              wb_reg    <= in_wb_reg;
              wb_data   <= 32'd0;
              addr_err  <= 1'b1;
              bad_vaddr <= in_alu_out;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_addr  <= {in_alu_out[31:2], 2'b00};
              bus_be    <= be_c;
              bus_wdata <= wdata_c;
              op_q      <= in_mem_op;
              off_q     <= off;
              reg_q     <= in_wb_reg;
              wen_q     <= in_wb_en;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            bus_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_reg   <= reg_q;
            if (op_q inside {[OP_SB:OP_SW]}) begin
              wb_en   <= 1'b0;
              wb_data <= 32'd0;
            end else begin
              wb_en   <= wen_q;
              wb_data <= load_align(op_q, off_q, bus_rdata);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized bench for mem_access against a transaction-level model
// Directed test-plan cases first, then random instructions with random bus wait states.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_mem_op;
  logic [31:0] in_alu_out, in_store_data;
  logic [4:0]  in_wb_reg;
  logic        in_wb_en;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic        wb_valid, wb_en, addr_err;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, bad_vaddr;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mem_op(in_mem_op),
    .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_wb_reg(in_wb_reg),
    .in_wb_en(in_wb_en), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .wb_valid(wb_valid), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .addr_err(addr_err), .bad_vaddr(bad_vaddr)
  );

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle
  logic        e_stall, e_req, e_we, e_wbv, e_wen, e_aerr;
  logic [31:0] e_addr, e_wdata, e_data, e_bad;
  logic [3:0]  e_be;
  logic [4:0]  e_reg;
  logic        e_rst, e_chk_reg, e_chk_data, chk_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic bit m_is_mem(input int op);
    return op >= 1 && op <= 8;
  endfunction
  function automatic bit m_is_store(input int op);
    return op >= 6 && op <= 8;
  endfunction
  function automatic int m_size(input int op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    return 4;
  endfunction
  function automatic logic [3:0] m_be(input int op, input int a);
    if (op == 6) return 4'(1 << a);
    if (op == 7) return (a == 0) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction
  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] d);
    if (op == 6) return (d & 32'hFF) * 32'h01010101;
    if (op == 7) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction
  function automatic logic [31:0] m_load(input int op, input int a, input logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * a)) & 32'hFF;
    h = (r >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      1: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      2: return b;
      3: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      4: return h;
      default: return r;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", stall, e_stall);
      chk("bus_req", bus_req, e_req);
      chk("wb_valid", wb_valid, e_wbv);
      chk("addr_err", addr_err, e_aerr);
      chk("bad_vaddr", bad_vaddr, e_bad);
      if (e_req || e_rst) begin
        chk("bus_we", bus_we, e_we);
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", bus_be, e_be);
        if (e_we || e_rst) chk("bus_wdata", bus_wdata, e_wdata);
      end
      if (e_wbv || e_rst) chk("wb_en", wb_en, e_wen);
      if ((e_wbv && e_chk_reg) || e_rst) chk("wb_reg", wb_reg, e_reg);
      if ((e_wbv && e_chk_data) || e_rst) chk("wb_data", wb_data, e_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_reset();
    e_stall = 0; e_req = 0; e_we = 0; e_wbv = 0; e_wen = 0; e_aerr = 0;
    e_addr = 0; e_wdata = 0; e_data = 0; e_bad = 0; e_be = 0; e_reg = 0;
    e_chk_reg = 0; e_chk_data = 0;
  endtask

  // Present one instruction, answer its bus request with ack in cycle k.
  task automatic run_instr(input bit v, input int op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [4:0] rg, input bit wen,
                           input int k, input logic [31:0] rd_ack);
    bit mem, al, st;
    mem = m_is_mem(op);
    st  = m_is_store(op);
    al  = (addr % m_size(op)) == 0;
    in_valid = v; in_mem_op = 4'(op); in_alu_out = addr; in_store_data = sd;
    in_wb_reg = rg; in_wb_en = wen;
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    e_stall = v && mem && al;
    step();
    e_aerr = 0; e_req = 0; e_wbv = 0;
    if (v && !mem) begin
      e_wbv = 1; e_wen = wen; e_reg = rg; e_data = addr; e_chk_reg = 1; e_chk_data = 1;
    end else if (v && !al) begin
      e_wbv = 1; e_wen = 0; e_aerr = 1; e_bad = addr; e_chk_reg = 0; e_chk_data = 0;
    end else if (v) begin
      e_req = 1; e_we = st; e_addr = addr & 32'hFFFFFFFC;
      e_be = m_be(op, int'(addr % 4)); e_wdata = m_wdata(op, sd);
      for (int c = 1; c <= k; c++) begin
        bus_ack = (c == k);
        bus_rdata = (c == k) ? rd_ack : $urandom;
        e_stall = !bus_ack;
        step();
      end
      e_req = 0; e_wbv = 1; e_chk_reg = 1; e_chk_data = 1; e_reg = rg;
      e_wen = st ? 1'b0 : wen;
      e_data = st ? 32'd0 : m_load(op, int'(addr % 4), rd_ack);
    end
    in_valid = 0; bus_ack = 0; e_stall = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_mem_op = 0; in_alu_out = 0; in_store_data = 0;
    in_wb_reg = 0; in_wb_en = 0; bus_rdata = 0; bus_ack = 0;
    chk_on = 0;
    exp_reset();
    e_rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1;
    step();
    rst_n = 1;
    e_rst = 0;
    step();

    chk("model_lb", m_load(1, 3, 32'h80FF0000), 32'hFFFFFF80);
    chk("model_sh_be", m_be(7, 2), 4'b1100);
    chk("model_sh_wdata", m_wdata(7, 32'hAAAABEEF), 32'hBEEFBEEF);

    run_instr(1, 0, 32'h12345678, 32'h0, 5'd3, 1, 1, 32'h0);
    chk("pt_data", wb_data, 32'h12345678);
    chk("pt_reg", wb_reg, 32'd3);

    run_instr(1, 1, 32'h00000103, 32'h0, 5'd7, 1, 3, 32'h80FF0000);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    run_instr(1, 2, 32'h00000103, 32'h0, 5'd7, 1, 3, 32'h80FF0000);
    chk("lbu_data", wb_data, 32'h00000080);

    run_instr(1, 7, 32'h00002002, 32'hAAAABEEF, 5'd9, 1, 2, 32'h0);
    chk("sh_wb_en", wb_en, 32'd0);

    run_instr(1, 5, 32'h00001001, 32'h0, 5'd4, 1, 1, 32'h0);
    chk("mis_err", addr_err, 32'd1);
    chk("mis_bad", bad_vaddr, 32'h00001001);
    chk("mis_wb_en", wb_en, 32'd0);
    run_instr(0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h0);

    // Reset while a load is outstanding, then a stray ack
    in_valid = 1; in_mem_op = 4'd5; in_alu_out = 32'h40; in_wb_reg = 5'd2; in_wb_en = 1;
    e_stall = 1;
    step();
    e_req = 1; e_we = 0; e_addr = 32'h40; e_be = 4'hF; e_wbv = 0; e_aerr = 0;
    #2;
    rst_n = 0;
    in_valid = 0;
    exp_reset();
    e_rst = 1;
    #1;
    chk("rst_req", bus_req, 32'd0);
    step();
    rst_n = 1;
    e_rst = 0;
    bus_ack = 1;
    step();
    bus_ack = 0;
    chk("stray_ack", wb_valid, 32'd0);

    run_instr(1, 5, 32'h00000800, 32'h0, 5'd5, 1, 1, 32'hCAFEF00D);
    chk("b2b_lw", wb_data, 32'hCAFEF00D);
    run_instr(1, 8, 32'h00000804, 32'h11223344, 5'd6, 1, 1, 32'h0);
    chk("b2b_sw", wb_valid, 32'd1);

    for (int n = 0; n < 400; n++) begin
      run_instr($urandom_range(0, 99) < 85, int'($urandom_range(0, 15)), $urandom, $urandom,
                5'($urandom), 1'($urandom), int'($urandom_range(1, 4)), $urandom);
    end
    step();

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
